// File: rtl/flog_top_top.sv
// Iterative bfloat16 log2 unit: operand capture, table lookup of log2(1.f), fixed-point add,
// then leading-one normalisation back to bfloat16 fields.
module flog_top_top #(
   parameter int EXP_WIDTH     = 8,
   parameter int FRACT_WIDTH   = 7,
   parameter int LUT_FRAC_BITS = 24
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   sign,
   input  logic [EXP_WIDTH-1:0]   exponent,
   input  logic [FRACT_WIDTH-1:0] fractional,
   input  logic                   valid_i,
   output logic                   s_res_o,
   output logic [EXP_WIDTH-1:0]   e_res_o,
   output logic [FRACT_WIDTH-1:0] f_res_o,
   output logic                   valid_o
);

   localparam int ResW    = 1 + EXP_WIDTH + FRACT_WIDTH;
   localparam int MagW    = EXP_WIDTH + LUT_FRAC_BITS;
   localparam int PosW    = $clog2(MagW);
   localparam int BiasInt = (1 << (EXP_WIDTH - 1)) - 1;
   localparam int ResBias = BiasInt - LUT_FRAC_BITS;
   localparam int LutSize = 1 << FRACT_WIDTH;

   localparam logic [EXP_WIDTH-1:0]   ExpMax   = '1;
   localparam logic [FRACT_WIDTH-1:0] QnanFrac = {1'b1, {(FRACT_WIDTH-1){1'b0}}};
   localparam logic [ResW-1:0] NegInf = {1'b1, ExpMax, {FRACT_WIDTH{1'b0}}};
   localparam logic [ResW-1:0] PosInf = {1'b0, ExpMax, {FRACT_WIDTH{1'b0}}};
   localparam logic [ResW-1:0] Qnan   = {1'b0, ExpMax, QnanFrac};

   typedef enum logic [2:0] {IDLE, LUT, ADD, NORM, DONE} state_t;

   // Elaboration-time log2(1 + idx/2^FRACT_WIDTH) by repeated squaring, one extra bit kept for rounding.
   function automatic logic [LUT_FRAC_BITS-1:0] log2Entry(input int idx);
      logic [127:0]           x;
      logic [LUT_FRAC_BITS:0] r;
      x = 128'(idx + LutSize) << (60 - FRACT_WIDTH);
      r = '0;
      for (int k = 0; k <= LUT_FRAC_BITS; k++) begin
         x = (x * x) >> 60;
         r = r << 1;
         if (x >= (128'd2 << 60)) begin
            r[0] = 1'b1;
            x    = x >> 1;
         end
      end
      r = r + 1'b1;
      return r[LUT_FRAC_BITS:1];
   endfunction

   logic [LUT_FRAC_BITS-1:0] lutRom [LutSize];

   for (genvar g = 0; g < LutSize; g++) begin : gLut
      localparam logic [LUT_FRAC_BITS-1:0] Entry = log2Entry(g);
      assign lutRom[g] = Entry;
   end

   state_t                   state_q, state_d;
   logic                     opSign_q;
   logic [EXP_WIDTH-1:0]     opExp_q;
   logic [FRACT_WIDTH-1:0]   opFrac_q;
   logic [EXP_WIDTH:0]       nInt_q, nInt_d;
   logic [LUT_FRAC_BITS-1:0] tab_q;
   logic                     special_q, special_d;
   logic [ResW-1:0]          specRes_q, specRes_d;
   logic                     sumNeg_q;
   logic [MagW-1:0]          mag_q, mag_d;
   logic [ResW-1:0]          res_q, res_d;
   logic                     valid_q, valid_d;
   logic [EXP_WIDTH+LUT_FRAC_BITS:0] sumS;
   logic [PosW-1:0]          leadPos;
   logic [MagW-1:0]          normShift;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      valid_d = 1'b0;
      case (state_q)
         IDLE:    if (valid_i) state_d = LUT;
         LUT:     state_d = ADD;
         ADD:     state_d = NORM;
         NORM:    state_d = DONE;
         DONE: begin
            valid_d = valid_i;
            if (!valid_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Special operands win over the arithmetic; exponent zero is checked first so -0 gives -inf.
   always_comb begin
      nInt_d    = {1'b0, opExp_q} - (EXP_WIDTH+1)'(BiasInt);
      special_d = 1'b1;
      specRes_d = '0;
      if (opExp_q == '0)                             specRes_d = NegInf;
      else if (opExp_q == ExpMax && opFrac_q != '0) specRes_d = Qnan;
      else if (opSign_q)                             specRes_d = Qnan;
      else if (opExp_q == ExpMax)                    specRes_d = PosInf;
      else                                           special_d = 1'b0;
   end

   // The signed fixed-point sum is just the integer part concatenated above the table fraction.
   always_comb begin
      sumS  = {nInt_q, tab_q};
      mag_d = sumS[MagW] ? (~sumS[MagW-1:0] + 1'b1) : sumS[MagW-1:0];
   end

   always_comb begin
      leadPos = '0;
      for (int i = 0; i < MagW; i++) begin
         if (mag_q[i]) leadPos = i[PosW-1:0];
      end
      normShift = mag_q << (PosW'(MagW - 1) - leadPos);
      res_d     = {sumNeg_q, EXP_WIDTH'(ResBias) + EXP_WIDTH'(leadPos),
                   normShift[MagW-2 -: FRACT_WIDTH]};
      if (special_q)        res_d = specRes_q;
      else if (mag_q == '0) res_d = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         opSign_q  <= 1'b0;
         opExp_q   <= '0;
         opFrac_q  <= '0;
         nInt_q    <= '0;
         tab_q     <= '0;
         special_q <= 1'b0;
         specRes_q <= '0;
         sumNeg_q  <= 1'b0;
         mag_q     <= '0;
         res_q     <= '0;
         valid_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (valid_i) begin
                  opSign_q <= sign;
                  opExp_q  <= exponent;
                  opFrac_q <= fractional;
               end
            end
            LUT: begin
               nInt_q    <= nInt_d;
               tab_q     <= lutRom[opFrac_q];
               special_q <= special_d;
               specRes_q <= specRes_d;
            end
            ADD: begin
               sumNeg_q <= nInt_q[EXP_WIDTH];
               mag_q    <= mag_d;
            end
            NORM:    res_q <= res_d;
            default: ;
         endcase
         valid_q <= valid_d;
      end
   end

   assign s_res_o = res_q[ResW-1];
   assign e_res_o = res_q[ResW-2 -: EXP_WIDTH];
   assign f_res_o = res_q[FRACT_WIDTH-1:0];
   assign valid_o = valid_q;

endmodule

// File: tb/tb_flog_top_top.sv
// Directed bench for flog_top_top: hand-computed vectors, specials, mid-operation reset,
// and random positive operands against a real-number log2 reference.
module tb_flog_top_top;

   logic       clk = 1'b0;
   logic       rst;
   logic       sign;
   logic [7:0] exponent;
   logic [6:0] fractional;
   logic       valid_i;
   logic       s_res_o;
   logic [7:0] e_res_o;
   logic [6:0] f_res_o;
   logic       valid_o;

   int tests = 0;
   int fails = 0;

   flog_top_top dut (
      .clk        (clk),
      .rst        (rst),
      .sign       (sign),
      .exponent   (exponent),
      .fractional (fractional),
      .valid_i    (valid_i),
      .s_res_o    (s_res_o),
      .e_res_o    (e_res_o),
      .f_res_o    (f_res_o),
      .valid_o    (valid_o)
   );

   always #5 clk = ~clk;

   // Reference: double-precision log2, truncated to the bfloat16 field layout.
   function automatic logic [15:0] modelLog2(input logic [7:0] e, input logic [6:0] f);
      real         r;
      logic [63:0] b;
      int          ex;
      if (e == 8'd0) return 16'hFF80;
      if (e == 8'hFF) return (f != 7'd0) ? 16'h7FC0 : 16'h7F80;
      r = real'(int'(e) - 127) + $ln(1.0 + real'(f) / 128.0) / $ln(2.0);
      if (r == 0.0) return 16'h0000;
      b  = $realtobits(r);
      ex = int'(b[62:52]) - 1023 + 127;
      return {b[63], ex[7:0], b[51:45]};
   endfunction

   task automatic checkBit(input string tag, input logic observed, input logic expected);
      tests++;
      assert (observed === expected) else begin
         fails++;
         $error("[TB] FAIL %s: got %b, expected %b", tag, observed, expected);
      end
   endtask

   task automatic checkOutput(input string tag, input logic [15:0] expRes, input int tol);
      logic [15:0] act;
      int          diff;
      act  = {s_res_o, e_res_o, f_res_o};
      diff = int'(act[14:0]) - int'(expRes[14:0]);
      if (diff < 0) diff = -diff;
      tests++;
      assert (!$isunknown(act) && act[15] === expRes[15] && diff <= tol) else begin
         fails++;
         $error("[TB] FAIL %s: got %h, expected %h (tol %0d ulp)", tag, act, expRes, tol);
      end
   endtask

   task automatic doReset();
      rst     = 1'b1;
      valid_i = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // Present an operand and wait (bounded) for valid_o; lat counts the capture edge as 1.
   task automatic applyStimulus(input logic s, input logic [7:0] e, input logic [6:0] f,
                                output int lat);
      @(negedge clk);
      sign       = s;
      exponent   = e;
      fractional = f;
      valid_i    = 1'b1;
      lat        = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
      end while (valid_o !== 1'b1 && lat < 12);
   endtask

   task automatic finishHandshake(input string tag);
      @(negedge clk);
      valid_i = 1'b0;
      @(posedge clk);
      #1;
      checkBit({tag, " valid drop"}, valid_o, 1'b0);
   endtask

   task automatic runCase(input string tag, input logic s, input logic [7:0] e,
                          input logic [6:0] f, input logic [15:0] expRes, input int tol);
      int lat;
      applyStimulus(s, e, f, lat);
      tests++;
      assert (lat === 5) else begin
         fails++;
         $error("[TB] FAIL %s latency: got %0d edges, expected 5", tag, lat);
      end
      checkOutput(tag, expRes, tol);
      finishHandshake(tag);
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int lat;
      logic [7:0]  re;
      logic [6:0]  rf;
      logic [15:0] expRes;

      sign = 1'b0; exponent = '0; fractional = '0;
      doReset();
      #1;
      checkOutput("reset outputs", 16'h0000, 0);
      checkBit("reset valid", valid_o, 1'b0);

      // 2^16 * 1.953125 -> 16.9658, with valid held for extra cycles
      applyStimulus(1'b0, 8'd143, 7'b1111010, lat);
      tests++;
      assert (lat === 5) else begin
         fails++;
         $error("[TB] FAIL main latency: got %0d edges, expected 5", lat);
      end
      checkOutput("main result", 16'h4187, 0);
      repeat (2) @(posedge clk);
      #1;
      checkBit("main valid held", valid_o, 1'b1);
      checkOutput("main result held", 16'h4187, 0);
      finishHandshake("main");

      runCase("x=1.0",      1'b0, 8'd127, 7'd0, 16'h0000, 0);
      runCase("x=2.0",      1'b0, 8'd128, 7'd0, 16'h3F80, 0);
      runCase("x=0.5",      1'b0, 8'd126, 7'd0, 16'hBF80, 0);
      runCase("x=2^-126",   1'b0, 8'd1,   7'd0, 16'hC2FC, 0);
      runCase("x=1+1/128",  1'b0, 8'd127, 7'd1, 16'h3C37, 1);
      runCase("zero",       1'b0, 8'd0,   7'd0, 16'hFF80, 0);
      runCase("neg zero",   1'b1, 8'd0,   7'd0, 16'hFF80, 0);
      runCase("negative",   1'b1, 8'd130, 7'd0, 16'h7FC0, 0);
      runCase("+inf",       1'b0, 8'd255, 7'd0, 16'h7F80, 0);
      runCase("nan in",     1'b0, 8'd255, 7'd5, 16'h7FC0, 0);

      // Leave a nonzero result in place, then reset while the next operand is in ADD
      runCase("pre-abort",  1'b0, 8'd128, 7'd0, 16'h3F80, 0);
      @(negedge clk);
      sign = 1'b0; exponent = 8'd140; fractional = 7'd33; valid_i = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      checkOutput("abort outputs", 16'h0000, 0);
      checkBit("abort valid", valid_o, 1'b0);
      @(negedge clk);
      valid_i = 1'b0;
      rst     = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      checkBit("abort valid stays low", valid_o, 1'b0);
      runCase("after abort", 1'b0, 8'd143, 7'b1111010, 16'h4187, 0);

      for (int i = 0; i < 100; i++) begin
         re     = 8'($urandom_range(255, 0));
         rf     = 7'($urandom_range(127, 0));
         expRes = modelLog2(re, rf);
         doReset();
         runCase($sformatf("random %0d e=%0d f=%0d", i, re, rf), 1'b0, re, rf, expRes,
                 (rf == 7'd0 || re == 8'd0 || re == 8'd255) ? 0 : 1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/flog_top_top.md
Name: flog_top_top

Overview:
- Iterative bfloat16 base-2 logarithm unit: accepts one bfloat16 operand (sign/exponent/fraction fields) under a level valid handshake.
- Returns log2(x) as bfloat16 fields after a fixed latency.
- Top level of the FLOG datapath, fed by a testbench/host that holds valid_i until valid_o is seen.

Parameters:
- EXP_WIDTH, 8, exponent field width (from flog_pkg).
- FRACT_WIDTH, 7, fraction field width (from flog_pkg).
- LUT_FRAC_BITS, 24, fractional precision of the internal log2(1.f) table.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- sign  in  1  operand sign.
- exponent  in  EXP_WIDTH  operand biased exponent (bias 127).
- fractional  in  FRACT_WIDTH  operand fraction (hidden 1 implied).
- valid_i  in  1  operand valid, level, held high until valid_o observed.
- s_res_o  out  1  result sign.
- e_res_o  out  EXP_WIDTH  result biased exponent.
- f_res_o  out  FRACT_WIDTH  result fraction.
- valid_o  out  1  result valid.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - s_res_o, e_res_o, f_res_o and valid_o are all 0.
  - Reset mid-operation aborts the computation; valid_o stays 0 until a new capture completes.
- FSM states: IDLE -> LUT -> ADD -> NORM -> DONE.
  - IDLE: on a rising edge with valid_i=1, register sign/exponent/fractional and go to LUT. Inputs are not sampled at any other time.
  - LUT: integer part n = exponent-127, as signed 9-bit. Table output T = log2(1+fractional/128) in unsigned Q0.24, rounded to nearest, 128 entries.
  - ADD: fixed-point sum S = n + T, in signed Q9.24. Then take sign and |S|.
  - NORM: leading-one detection on |S|, derive exponent = 127 + position of the leading one, truncate mantissa to 7 bits (round toward zero), pack the result registers.
  - DONE: valid_o=1, outputs stable. Stay in DONE while valid_i=1. Return to IDLE on the first edge with valid_i=0, clearing valid_o.
- Latency: capture on edge N gives valid_o high after edge N+4. Result registers hold their value until the next capture's NORM stage.
- Accuracy: the result equals single-precision log2(x) truncated to its top 16 bits, within 1 ulp of f_res_o. Exact integers (x = 2^k) must match exactly.
- Special cases, resolved in the LUT stage and bypassing the arithmetic:
  - exponent=0 (zero or subnormal, flushed), either sign -> -inf: 1, 0xFF, 0x00.
  - sign=1 with nonzero normal value -> qNaN: 0, 0xFF, 0x40.
  - exponent=0xFF, fraction=0, sign=0 -> +inf: 0, 0xFF, 0x00.
  - exponent=0xFF, fraction≠0 -> qNaN: 0, 0xFF, 0x40.
  - S=0 (x=1.0) -> +0: 0, 0x00, 0x00.
- Results never overflow: |log2| ≤ 128, so e_res_o ≤ 134 for finite results.

Test Plan:
- Reset, then exponent=143, fractional=1111010, sign=0, valid_i=1 -> valid_o 4 cycles after capture. Result 0, 10000011, 0000111 (16.9658). valid_o stays high while valid_i=1 and drops one edge after valid_i=0.
- Power-of-two inputs, exactly:
  - x=1.0 (127, 0) -> 0, 0, 0.
  - x=2.0 (128, 0) -> 0, 127, 0.
  - x=0.5 (126, 0) -> 1, 127, 0.
  - (1, 0) -> 1, 133, 1111100 (-126).
- Small-magnitude result: (127, 0000001) -> 0, 120, 0110111, within 1 ulp.
- Special cases:
  - (0, 0, 0) -> 1, 255, 0.
  - sign=1, exponent=130 -> 0, 255, 1000000.
  - (0, 255, 0) -> 0, 255, 0.
  - (0, 255, 0000101) -> 0, 255, 1000000.
- Assert rst during the ADD state -> all outputs 0 immediately. A following valid transaction completes normally with correct results.
- 100 random sign-0 operands (exponent 0..255, fraction 0..127), with reset and a full handshake between each -> every result within 1 ulp of truncated single-precision log2, and specials as listed.
